imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_pack.sv | 49 ++++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared definitions for the instruction-memory loader.
//   WORD_W     : width of one instruction-memory word (32)
//   ADDR_W_DEF : default word-address width of the loader
//   state_e    : loader FSM state encoding
// The CHECK state only exists when IMEM_LOADER_CHKSUM_EN is defined.
package imem_loader_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned ADDR_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RECV  = 3'd2,
      ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHKSUM_EN
      ST_CHECK = 3'd4,
`endif
      ST_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/imem_loader_pack.sv
// imem_loader_pack -- assembles four bytes, MSB first, into one 32-bit word.
//   clk_i, rst_i   : clock, async active-high reset
//   clr_i          : synchronous clear of byte counter and partial word
//   byte_en_i      : a byte is accepted this cycle
//   byte_i         : the byte
//   word_o         : assembled word (valid the cycle after word_done_o)
//   word_done_o    : the 4th byte of a word is being accepted this cycle
module imem_loader_pack
   import imem_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              byte_en_i,
   input  logic [7:0]        byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_done_o
);

   logic [1:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] word_q, word_d;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clr_i) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (byte_en_i) begin
         cnt_d  = cnt_q + 2'd1;
         // shifting left puts the first byte of the word in bits 31:24
         word_d = {word_q[WORD_W-9:0], byte_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign word_done_o = byte_en_i && !clr_i && (cnt_q == 2'd3);
   assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- clears instruction memory, loads a byte stream into it as
// 32-bit words, then releases the CPU via start_o.
//   clk_i, rst_i          : clock, async active-high reset
//   load_req_i            : start a load (honoured only in IDLE or DONE)
//   word_count_i          : words to load, clamped to 2^ADDR_W
//   byte_valid_i, byte_i  : source byte stream
//   byte_ready_o          : byte accepted when byte_valid_i && byte_ready_o
//   mem_we_o/addr_o/data_o: instruction-memory write port
//   start_o               : CPU start, high in DONE without error
//   busy_o, done_o, err_o : status
// Optional: IMEM_LOADER_CHKSUM_EN adds a trailing XOR checksum byte checked
// in the CHECK state; without it err_o is tied low.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_req_i,
   input  logic [ADDR_W:0]   word_count_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_i,
   output logic              byte_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_data_o,
   output logic              start_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

`ifdef IMEM_LOADER_CHKSUM_EN
   localparam state_e ST_FINAL = ST_CHECK;
`else
   localparam state_e ST_FINAL = ST_DONE;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   wcnt_q, wcnt_d;
   logic [ADDR_W:0]   wcnt_inc;
   logic              load_go;
   logic              pack_en;
   logic              word_done;
   logic [WORD_W-1:0] word;

`ifdef IMEM_LOADER_CHKSUM_EN
   logic              err_q, err_d;
   logic [7:0]        chk_q, chk_d;
`endif

   assign load_go  = load_req_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign pack_en  = (state_q == ST_RECV) && byte_valid_i;
   assign wcnt_inc = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};

   imem_loader_pack u_pack (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (load_go),
      .byte_en_i   (pack_en),
      .byte_i      (byte_i),
      .word_o      (word),
      .word_done_o (word_done)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
`ifdef IMEM_LOADER_CHKSUM_EN
      err_d   = err_q;
      chk_d   = chk_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_go) begin
               cnt_d   = (word_count_i > MAX_CNT) ? MAX_CNT : word_count_i;
               wcnt_d  = '0;
               addr_d  = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
               err_d   = 1'b0;
               chk_d   = '0;
`endif
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // address wraps back to 0 after the last location, ready for RECV
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (&addr_q) state_d = (cnt_q == '0) ? ST_FINAL : ST_RECV;
         end
         ST_RECV: begin
`ifdef IMEM_LOADER_CHKSUM_EN
            if (byte_valid_i) chk_d = chk_q ^ byte_i;
`endif
            if (word_done) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            wcnt_d  = wcnt_inc;
            state_d = (wcnt_inc == cnt_q) ? ST_FINAL : ST_RECV;
         end
`ifdef IMEM_LOADER_CHKSUM_EN
         ST_CHECK: begin
            if (byte_valid_i) begin
               err_d   = (byte_i != chk_q);
               state_d = ST_DONE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
         err_q   <= 1'b0;
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
`ifdef IMEM_LOADER_CHKSUM_EN
         err_q   <= err_d;
         chk_q   <= chk_d;
`endif
      end
   end

`ifdef IMEM_LOADER_CHKSUM_EN
   assign err_o        = err_q;
   assign byte_ready_o = (state_q == ST_RECV) || (state_q == ST_CHECK);
   assign busy_o       = (state_q == ST_CLEAR) || (state_q == ST_RECV) ||
                         (state_q == ST_WRITE) || (state_q == ST_CHECK);
`else
   assign err_o        = 1'b0;
   assign byte_ready_o = (state_q == ST_RECV);
   assign busy_o       = (state_q == ST_CLEAR) || (state_q == ST_RECV) ||
                         (state_q == ST_WRITE);
`endif

   assign mem_we_o   = (state_q == ST_CLEAR) || (state_q == ST_WRITE);
   assign mem_addr_o = mem_we_o ? addr_q : '0;
   assign mem_data_o = (state_q == ST_WRITE) ? word : '0;
   assign done_o     = (state_q == ST_DONE);
   assign start_o    = done_o && !err_o;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              rst;
   logic              load_req;
   logic [ADDR_W:0]   word_count;
   logic              byte_valid;
   logic [7:0]        byte_in;
   logic              byte_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_data_o;
   logic              start_o, busy_o, done_o, err_o;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  wa_q[$];
   logic [31:0] wd_q[$];
   bit          rdy_seen;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_req_i   (load_req),
      .word_count_i (word_count),
      .byte_valid_i (byte_valid),
      .byte_i       (byte_in),
      .byte_ready_o (byte_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .start_o      (start_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write log, sampled mid-cycle
   always @(negedge clk) begin
      if (mem_we_o) begin
         wa_q.push_back(mem_addr_o);
         wd_q.push_back(mem_data_o);
      end
      if (byte_ready_o) rdy_seen = 1'b1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      rdy_seen = 1'b0;
   endtask

   task automatic start_load(input logic [ADDR_W:0] n);
      load_req   = 1'b1;
      word_count = n;
      cyc();
      load_req   = 1'b0;
      word_count = '0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      bit ok;
      t  = 0;
      ok = 1'b0;
      byte_valid = 1'b1;
      byte_in    = b;
      while (!ok && t < 3000) begin
         @(negedge clk);
         if (byte_ready_o) begin
            cyc();
            ok = 1'b1;
         end
         t++;
      end
      byte_valid = 1'b0;
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL send_byte timeout byte %h never accepted", b);
      end
      if (gap) cyc();
   endtask

   task automatic wait_done(input int lim);
      int t;
      t = 0;
      while (!done_o && t < lim) begin
         @(negedge clk);
         t++;
      end
      if (!done_o) begin
         n_vec++; n_err++;
         $display("FAIL wait_done timeout after %0d cycles, done_o got 0 exp 1", lim);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      n_vec++; if (busy_o !== 1'b0)       begin n_err++; $display("FAIL reset busy_o got %b exp 0", busy_o); end
      n_vec++; if (done_o !== 1'b0)       begin n_err++; $display("FAIL reset done_o got %b exp 0", done_o); end
      n_vec++; if (start_o !== 1'b0)      begin n_err++; $display("FAIL reset start_o got %b exp 0", start_o); end
      n_vec++; if (err_o !== 1'b0)        begin n_err++; $display("FAIL reset err_o got %b exp 0", err_o); end
      n_vec++; if (mem_we_o !== 1'b0)     begin n_err++; $display("FAIL reset mem_we_o got %b exp 0", mem_we_o); end
      n_vec++; if (byte_ready_o !== 1'b0) begin n_err++; $display("FAIL reset byte_ready_o got %b exp 0", byte_ready_o); end
      n_vec++; if (mem_addr_o !== 8'h00)  begin n_err++; $display("FAIL reset mem_addr_o got %h exp 00", mem_addr_o); end
      n_vec++; if (mem_data_o !== 32'h0)  begin n_err++; $display("FAIL reset mem_data_o got %h exp 0", mem_data_o); end
      rst = 1'b0;
      cyc();
      n_vec++; if (busy_o !== 1'b0)       begin n_err++; $display("FAIL idle busy_o got %b exp 0", busy_o); end
   endtask

   task automatic test_load_two();
      logic [7:0] b [8];
      int bad;
      b = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h20, 8'h02, 8'h00, 8'h05};
      clear_log();
      start_load(9'd2);
      for (int i = 0; i < 8; i++) send_byte(b[i], 1'b0);
      @(negedge clk);
      n_vec++; if (mem_we_o !== 1'b1)            begin n_err++; $display("FAIL load2 write we got %b exp 1", mem_we_o); end
      n_vec++; if (mem_addr_o !== 8'h01)         begin n_err++; $display("FAIL load2 write addr got %h exp 01", mem_addr_o); end
      n_vec++; if (mem_data_o !== 32'h20020005)  begin n_err++; $display("FAIL load2 write data got %h exp 20020005", mem_data_o); end
      n_vec++; if (byte_ready_o !== 1'b0)        begin n_err++; $display("FAIL load2 write ready got %b exp 0", byte_ready_o); end
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(8'hAA, 1'b0);
`endif
      @(negedge clk);
      n_vec++; if (done_o !== 1'b1)  begin n_err++; $display("FAIL load2 done_o got %b exp 1", done_o); end
      n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL load2 start_o got %b exp 1", start_o); end
      n_vec++; if (busy_o !== 1'b0)  begin n_err++; $display("FAIL load2 busy_o got %b exp 0", busy_o); end
      n_vec++; if (wa_q.size() != 258) begin n_err++; $display("FAIL load2 write count got %0d exp 258", wa_q.size()); end
      bad = 0;
      for (int i = 0; i < 256 && i < wa_q.size(); i++)
         if (wa_q[i] !== i[7:0] || wd_q[i] !== 32'h0) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL load2 clear writes bad got %0d exp 0", bad); end
      if (wa_q.size() >= 258) begin
         n_vec++; if (wa_q[256] !== 8'h00 || wd_q[256] !== 32'h8C010000)
            begin n_err++; $display("FAIL load2 word0 got %h@%h exp 8c010000@00", wd_q[256], wa_q[256]); end
         n_vec++; if (wa_q[257] !== 8'h01 || wd_q[257] !== 32'h20020005)
            begin n_err++; $display("FAIL load2 word1 got %h@%h exp 20020005@01", wd_q[257], wa_q[257]); end
      end
   endtask

   task automatic test_count_zero();
      int bad;
      clear_log();
      start_load(9'd0);
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(8'h00, 1'b0);
`endif
      wait_done(400);
      @(negedge clk);
      n_vec++; if (wa_q.size() != 256) begin n_err++; $display("FAIL count0 write count got %0d exp 256", wa_q.size()); end
      bad = 0;
      for (int i = 0; i < wa_q.size(); i++)
         if (wa_q[i] !== i[7:0] || wd_q[i] !== 32'h0) bad++;
      n_vec++; if (bad != 0)         begin n_err++; $display("FAIL count0 clear writes bad got %0d exp 0", bad); end
      n_vec++; if (done_o !== 1'b1)  begin n_err++; $display("FAIL count0 done_o got %b exp 1", done_o); end
      n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL count0 start_o got %b exp 1", start_o); end
`ifndef IMEM_LOADER_CHKSUM_EN
      n_vec++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL count0 byte_ready seen got %b exp 0", rdy_seen); end
`endif
   endtask

   task automatic test_gaps();
      logic [7:0] b [4];
      b = '{8'h12, 8'h34, 8'h56, 8'h78};
      clear_log();
      start_load(9'd1);
      for (int i = 0; i < 4; i++) send_byte(b[i], 1'b1);
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(8'h08, 1'b0);
`endif
      wait_done(50);
      repeat (3) @(negedge clk);
      n_vec++; if (wa_q.size() != 257) begin n_err++; $display("FAIL gaps write count got %0d exp 257", wa_q.size()); end
      if (wa_q.size() >= 257) begin
         n_vec++; if (wa_q[256] !== 8'h00 || wd_q[256] !== 32'h12345678)
            begin n_err++; $display("FAIL gaps word got %h@%h exp 12345678@00", wd_q[256], wa_q[256]); end
      end
      n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL gaps start_o got %b exp 1", start_o); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b [6];
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
      clear_log();
      start_load(9'd2);
      for (int i = 0; i < 6; i++) send_byte(b[i], 1'b0);
      rst = 1'b1;
      #1;
      n_vec++; if (busy_o !== 1'b0)       begin n_err++; $display("FAIL rstmid busy_o got %b exp 0", busy_o); end
      n_vec++; if (byte_ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid byte_ready_o got %b exp 0", byte_ready_o); end
      n_vec++; if (mem_we_o !== 1'b0 || mem_addr_o !== 8'h00 || mem_data_o !== 32'h0)
         begin n_err++; $display("FAIL rstmid mem port got we=%b addr=%h data=%h exp 0/00/0", mem_we_o, mem_addr_o, mem_data_o); end
      n_vec++; if (start_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0)
         begin n_err++; $display("FAIL rstmid status got start=%b done=%b err=%b exp 000", start_o, done_o, err_o); end
      cyc();
      rst = 1'b0;
      cyc();
      clear_log();
      start_load(9'd1);
      send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
      send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(8'h22, 1'b0);
`endif
      wait_done(50);
      n_vec++; if (wa_q.size() != 257) begin n_err++; $display("FAIL rstmid reload count got %0d exp 257", wa_q.size()); end
      if (wa_q.size() >= 257) begin
         n_vec++; if (wa_q[256] !== 8'h00 || wd_q[256] !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL rstmid reload word got %h@%h exp deadbeef@00", wd_q[256], wa_q[256]); end
      end
      n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL rstmid reload start_o got %b exp 1", start_o); end
   endtask

   task automatic test_ignore_restart();
      clear_log();
      start_load(9'd1);
      send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
      load_req   = 1'b1;
      word_count = 9'd0;
      cyc();
      load_req   = 1'b0;
      n_vec++; if (busy_o !== 1'b1 || byte_ready_o !== 1'b1 || mem_we_o !== 1'b0)
         begin n_err++; $display("FAIL ignore state got busy=%b ready=%b we=%b exp 1/1/0", busy_o, byte_ready_o, mem_we_o); end
      send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(8'h44, 1'b0);
`endif
      wait_done(50);
      @(negedge clk);
      n_vec++; if (wa_q.size() != 257) begin n_err++; $display("FAIL ignore write count got %0d exp 257", wa_q.size()); end
      if (wa_q.size() >= 257) begin
         n_vec++; if (wd_q[256] !== 32'h11223344) begin n_err++; $display("FAIL ignore word got %h exp 11223344", wd_q[256]); end
      end
      n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL ignore start_o got %b exp 1", start_o); end
      start_load(9'd0);
      n_vec++; if (start_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL restart status got start=%b done=%b exp 00", start_o, done_o); end
      n_vec++; if (busy_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 8'h00)
         begin n_err++; $display("FAIL restart clear got busy=%b we=%b addr=%h exp 1/1/00", busy_o, mem_we_o, mem_addr_o); end
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(8'h00, 1'b0);
`endif
      wait_done(400);
      n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL restart final start_o got %b exp 1", start_o); end
   endtask

   task automatic test_clamp();
      int k;
      clear_log();
      start_load(9'h1FF);
      for (k = 0; k < 1024; k++) send_byte(k[7:0], 1'b0);
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(8'h00, 1'b0);
`endif
      wait_done(50);
      n_vec++; if (wa_q.size() != 512) begin n_err++; $display("FAIL clamp write count got %0d exp 512", wa_q.size()); end
      if (wa_q.size() >= 512) begin
         n_vec++; if (wa_q[256] !== 8'h00 || wd_q[256] !== 32'h00010203)
            begin n_err++; $display("FAIL clamp first word got %h@%h exp 00010203@00", wd_q[256], wa_q[256]); end
         n_vec++; if (wa_q[511] !== 8'hFF || wd_q[511] !== 32'hFCFDFEFF)
            begin n_err++; $display("FAIL clamp last word got %h@%h exp fcfdfeff@ff", wd_q[511], wa_q[511]); end
      end
      n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL clamp start_o got %b exp 1", start_o); end
   endtask

`ifdef IMEM_LOADER_CHKSUM_EN
   task automatic test_chksum();
      logic [7:0] b [4];
      b = '{8'h12, 8'h34, 8'h56, 8'h78};
      start_load(9'd1);
      for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0);
      send_byte(8'h08, 1'b0);
      wait_done(50);
      n_vec++; if (start_o !== 1'b1 || err_o !== 1'b0) begin n_err++; $display("FAIL chk good got start=%b err=%b exp 1/0", start_o, err_o); end
      start_load(9'd1);
      for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0);
      send_byte(8'h09, 1'b0);
      wait_done(50);
      n_vec++; if (start_o !== 1'b0 || err_o !== 1'b1 || done_o !== 1'b1)
         begin n_err++; $display("FAIL chk bad got start=%b err=%b done=%b exp 0/1/1", start_o, err_o, done_o); end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      load_req   = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_in    = '0;
      rdy_seen   = 1'b0;
      test_reset();
      test_load_two();
      test_count_zero();
      test_gaps();
      test_reset_mid();
      test_ignore_restart();
      test_clamp();
`ifdef IMEM_LOADER_CHKSUM_EN
      test_chksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
